// File: rtl/ahb_read_mux.sv
// AHB read-data / response multiplexer with a built-in default slave.
// The data-phase select is registered on each accepted address phase. An
// unmapped or ambiguous select routes the bus to a default slave. That slave
// answers IDLE/BUSY with a zero-wait OKAY and NONSEQ/SEQ with a two-cycle
// ERROR, and counts those ERRORs in a saturating counter.
module ahb_read_mux #(
  parameter int unsigned NSLV = 16,
  parameter int unsigned W    = 32
) (
  input  logic             HCLK,
  input  logic             HRST,
  input  logic [NSLV-1:0]  HSEL_i,
  input  logic [1:0]       HTRANS_i,
  input  logic [W-1:0]     HRDATA_i [NSLV-1:0],
  input  logic [NSLV-1:0]  HREADYOUT_i,
  input  logic [NSLV-1:0]  HRESP_i,
  output logic [W-1:0]     HRDATA_o,
  output logic             HREADY_o,
  output logic             HRESP_o,
  output logic [7:0]       err_cnt_o
);

  localparam int unsigned IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {
    DS_OK,
    DS_ERR1,
    DS_ERR2
  } ds_state_e;

  // Data-phase select: sel_def_q set means the default slave owns the bus.
  logic          sel_def_q, sel_def_d;
  logic [IW-1:0] sel_idx_q, sel_idx_d;

  ds_state_e     ds_q, ds_d;
  logic          ds_hready_q, ds_hready_d;
  logic          ds_hresp_q, ds_hresp_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  int unsigned   one_cnt;
  logic [IW-1:0] one_idx;
  logic          trans_active;
  logic          err_start;

  // Address-phase decode, select register next state, default-slave FSM next state.
  always_comb begin
    one_cnt = 0;
    one_idx = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (HSEL_i[i]) begin
        one_cnt = one_cnt + 1;
        one_idx = IW'(i);
      end
    end

    trans_active = (HTRANS_i == 2'b10) || (HTRANS_i == 2'b11);

    sel_def_d = sel_def_q;
    sel_idx_d = sel_idx_q;
    if (HREADY_o) begin
      sel_def_d = (one_cnt != 1);
      sel_idx_d = (one_cnt == 1) ? one_idx : '0;
    end

    // An ERROR starts only when an accepted address phase decodes to the
    // default slave with an active transfer type.
    err_start = HREADY_o && (one_cnt != 1) && trans_active;

    ds_d = ds_q;
    case (ds_q)
      DS_OK:   ds_d = err_start ? DS_ERR1 : DS_OK;
      DS_ERR1: ds_d = DS_ERR2;
      DS_ERR2: ds_d = err_start ? DS_ERR1 : DS_OK;
      default: ds_d = DS_OK;
    endcase

    // Outputs are decoded from the next state so they come straight from flops.
    ds_hready_d = (ds_d != DS_ERR1);
    ds_hresp_d  = (ds_d != DS_OK);

    err_cnt_d = err_cnt_q;
    if ((ds_d == DS_ERR1) && (ds_q != DS_ERR1) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Select register, default-slave FSM with registered outputs, and error counter.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      sel_def_q   <= 1'b1;
      sel_idx_q   <= '0;
      ds_q        <= DS_OK;
      ds_hready_q <= 1'b1;
      ds_hresp_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      sel_def_q   <= sel_def_d;
      sel_idx_q   <= sel_idx_d;
      ds_q        <= ds_d;
      ds_hready_q <= ds_hready_d;
      ds_hresp_q  <= ds_hresp_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Data-phase return path: selected slave passes through with no added latency.
  always_comb begin
    if (sel_def_q) begin
      HRDATA_o = '0;
      HREADY_o = ds_hready_q;
      HRESP_o  = ds_hresp_q;
    end else begin
      HRDATA_o = HRDATA_i[sel_idx_q];
      HREADY_o = HREADYOUT_i[sel_idx_q];
      HRESP_o  = HRESP_i[sel_idx_q];
    end
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_ahb_read_mux.sv
// Bench for ahb_read_mux: a transaction-level model plus directed scenarios.
module tb_ahb_read_mux;

  logic        HCLK = 1'b0;
  logic        HRST;
  logic [15:0] HSEL_i;
  logic [1:0]  HTRANS_i;
  logic [31:0] HRDATA_i [15:0];
  logic [15:0] HREADYOUT_i;
  logic [15:0] HRESP_i;
  logic [31:0] HRDATA_o;
  logic        HREADY_o;
  logic        HRESP_o;
  logic [7:0]  err_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  ahb_read_mux #(.NSLV(16), .W(32)) dut (
    .HCLK       (HCLK),
    .HRST       (HRST),
    .HSEL_i     (HSEL_i),
    .HTRANS_i   (HTRANS_i),
    .HRDATA_i   (HRDATA_i),
    .HREADYOUT_i(HREADYOUT_i),
    .HRESP_i    (HRESP_i),
    .HRDATA_o   (HRDATA_o),
    .HREADY_o   (HREADY_o),
    .HRESP_o    (HRESP_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which slave owns the data phase (-1 = default), how far into an
  // ERROR response the default slave is (0 none, 1 first cycle, 2 second).
  int m_sel   = -1;
  int m_phase = 0;
  int m_cnt   = 0;

  function automatic logic exp_ready();
    if (m_sel < 0) return (m_phase != 1);
    return HREADYOUT_i[m_sel];
  endfunction

  function automatic logic exp_resp();
    if (m_sel < 0) return (m_phase != 0);
    return HRESP_i[m_sel];
  endfunction

  function automatic logic [31:0] exp_data();
    if (m_sel < 0) return 32'h0;
    return HRDATA_i[m_sel];
  endfunction

  always @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      m_sel = -1; m_phase = 0; m_cnt = 0;
    end else if (exp_ready()) begin
      m_sel = -1;
      if ($countones(HSEL_i) == 1)
        for (int i = 0; i < 16; i++) if (HSEL_i[i]) m_sel = i;
      if (m_sel < 0 && HTRANS_i[1]) begin
        m_phase = 1;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_phase = 0;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end
  end

  always @(negedge HCLK) begin
    chk("cmp_hready", {31'b0, HREADY_o}, {31'b0, exp_ready()});
    chk("cmp_hresp",  {31'b0, HRESP_o},  {31'b0, exp_resp()});
    chk("cmp_hrdata", HRDATA_o, exp_data());
    chk("cmp_errcnt", {24'b0, err_cnt_o}, m_cnt);
  end

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic lit(input string name, input logic r, input logic e,
                     input logic [31:0] d, input logic [7:0] c);
    chk({name, "_hready"}, {31'b0, HREADY_o}, {31'b0, r});
    chk({name, "_hresp"},  {31'b0, HRESP_o},  {31'b0, e});
    chk({name, "_hrdata"}, HRDATA_o, d);
    chk({name, "_errcnt"}, {24'b0, err_cnt_o}, {24'b0, c});
  endtask

  initial begin
    HRST = 1'b1;
    HSEL_i = 16'h0; HTRANS_i = 2'b00;
    HREADYOUT_i = 16'hFFFF; HRESP_i = 16'h0;
    for (int i = 0; i < 16; i++) HRDATA_i[i] = 32'h1000_0000 + i;
    #12;
    lit("reset", 1'b1, 1'b0, 32'h0, 8'h00);

    // First address phase accepted on the first edge after release.
    HSEL_i = 16'h0004; HTRANS_i = 2'b10;
    HRST = 1'b0;
    cyc();
    HSEL_i = 16'h0; HTRANS_i = 2'b00;
    HRDATA_i[2] = 32'hDEADBEEF;
    @(negedge HCLK);
    lit("slave2_read", 1'b1, 1'b0, 32'hDEADBEEF, 8'h00);
    cyc();

    // Slave 5 with three wait states; new select during wait is ignored.
    HSEL_i = 16'h0020; HTRANS_i = 2'b10;
    cyc();
    HREADYOUT_i[5] = 1'b0;
    HRDATA_i[5] = 32'h5555_5555;
    HRDATA_i[0] = 32'h0A0A_0A0A;
    HSEL_i = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("wait_hready", {31'b0, HREADY_o}, 32'h0);
      cyc();
    end
    HREADYOUT_i[5] = 1'b1;
    @(negedge HCLK);
    lit("slave5_done", 1'b1, 1'b0, 32'h5555_5555, 8'h00);
    cyc();
    HSEL_i = 16'h0; HTRANS_i = 2'b10;
    @(negedge HCLK);
    lit("slave0_read", 1'b1, 1'b0, 32'h0A0A_0A0A, 8'h00);

    // Unmapped NONSEQ: two-cycle ERROR, counter 0 -> 1.
    cyc();
    HTRANS_i = 2'b00;
    @(negedge HCLK);
    lit("err1", 1'b0, 1'b1, 32'h0, 8'h01);
    cyc();
    @(negedge HCLK);
    lit("err2", 1'b1, 1'b1, 32'h0, 8'h01);
    cyc();
    @(negedge HCLK);
    lit("idle_ok", 1'b1, 1'b0, 32'h0, 8'h01);

    // Multi-hot SEQ: ERROR; then ERR2 followed directly by another ERROR.
    HSEL_i = 16'h0003; HTRANS_i = 2'b11;
    cyc();
    HSEL_i = 16'h0; HTRANS_i = 2'b00;
    @(negedge HCLK);
    lit("multi_err1", 1'b0, 1'b1, 32'h0, 8'h02);
    cyc();
    HTRANS_i = 2'b10;
    @(negedge HCLK);
    lit("multi_err2", 1'b1, 1'b1, 32'h0, 8'h02);
    cyc();
    HTRANS_i = 2'b01;
    @(negedge HCLK);
    lit("b2b_err1", 1'b0, 1'b1, 32'h0, 8'h03);
    cyc();
    cyc();
    @(negedge HCLK);
    lit("busy_ok", 1'b1, 1'b0, 32'h0, 8'h03);

    // Slave-originated ERROR passes through without counting.
    HSEL_i = 16'h0004; HTRANS_i = 2'b10;
    cyc();
    HSEL_i = 16'h0; HTRANS_i = 2'b00;
    HRESP_i[2] = 1'b1;
    @(negedge HCLK);
    lit("slave_err", 1'b1, 1'b1, 32'hDEADBEEF, 8'h03);
    cyc();
    HRESP_i[2] = 1'b0;

    // Continuous unmapped NONSEQ: 310 ERRORs, counter saturates.
    HTRANS_i = 2'b10;
    for (int i = 0; i < 620; i++) cyc();
    @(negedge HCLK);
    chk("sat_errcnt", {24'b0, err_cnt_o}, 32'h0000_00FF);

    // Return to OKAY, start an ERROR, then reset inside its first cycle.
    HTRANS_i = 2'b00;
    cyc(); cyc();
    HTRANS_i = 2'b10;
    cyc();
    HTRANS_i = 2'b00;
    #1;
    chk("pre_rst_hready", {31'b0, HREADY_o}, 32'h0);
    HRST = 1'b1;
    #1;
    lit("mid_err_reset", 1'b1, 1'b0, 32'h0, 8'h00);
    cyc();
    #2;
    HSEL_i = 16'h0004; HTRANS_i = 2'b10;
    HRST = 1'b0;
    cyc();
    HSEL_i = 16'h0;
    @(negedge HCLK);
    lit("post_reset", 1'b1, 1'b0, 32'hDEADBEEF, 8'h00);
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_read_mux.md
AHB_READ_MUX -- requirements
Module: ahb_read_mux

Interface
REQ-001 Parameter: NSLV, 16, number of attached slaves; legal range 1..16.
REQ-002 Parameter: `AHB_BUS_WIDTH (ahb_defines.v), 32, data width W.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 Port: HCLK  in  1  bus clock; all state updates on rising edge.
REQ-005 Port: HRST  in  1  asynchronous active-high reset.
REQ-006 Port: HSEL_i  in  NSLV  address-phase slave selects from the address decoder; expected one-hot or zero.
REQ-007 Port: HTRANS_i  in  2  address-phase transfer type of the granted master.
REQ-008 Port: HRDATA_i  in  W x NSLV (unpacked [NSLV-1:0])  slave read data.
REQ-009 Port: HREADYOUT_i  in  NSLV  per-slave ready.
REQ-010 Port: HRESP_i  in  NSLV  per-slave response; 1 = ERROR.
REQ-011 Port: HRDATA_o  out  W  read data to masters.
REQ-012 Port: HREADY_o  out  1  bus ready to masters and back to all slaves.
REQ-013 Port: HRESP_o  out  1  bus response to masters.
REQ-014 Port: err_cnt_o  out  8  saturating count of default-slave ERROR responses.

Function
REQ-015 Address phase is valid when HREADY_o = 1; only then shall the data-phase select register sel_q be loaded.
REQ-016 When HSEL_i is exactly one-hot with bit k < NSLV, sel_q shall load slave k; otherwise sel_q shall load DEFAULT.
- Covers zero, multiple bits set, and a bit >= NSLV.
REQ-017 When HREADY_o = 0, sel_q shall hold its value and HSEL_i/HTRANS_i shall be ignored.
REQ-018 With sel_q = slave k: HRDATA_o = HRDATA_i[k], HREADY_o = HREADYOUT_i[k], HRESP_o = HRESP_i[k], combinationally with zero added latency.
REQ-019 With sel_q = DEFAULT: HRDATA_o = 0, and HREADY_o and HRESP_o shall come from the default-slave FSM.
REQ-020 Default-slave FSM states: DS_OK, DS_ERR1, DS_ERR2.
REQ-021 DS_OK -> DS_ERR1 when an address phase is accepted (REQ-015) with DEFAULT selected and HTRANS_i = NONSEQ (2'b10) or SEQ (2'b11).
REQ-022 DS_ERR1 -> DS_ERR2 unconditionally after one cycle.
REQ-023 DS_ERR2 -> DS_OK unconditionally, unless REQ-021 fires in the same cycle, in which case -> DS_ERR1.
REQ-024 Default-slave outputs per state:
- DS_OK: HREADY 1, HRESP 0.
- DS_ERR1: HREADY 0, HRESP 1.
- DS_ERR2: HREADY 1, HRESP 1.
- Gives the two-cycle AHB ERROR response.
REQ-025 IDLE (2'b00) or BUSY (2'b01) to DEFAULT shall produce a zero-wait OKAY: FSM stays in DS_OK.
REQ-026 An address phase accepted in DS_ERR2 shall be registered normally.
- The master may drive IDLE there, which makes the next data phase OKAY.
REQ-027 err_cnt_o shall increment by 1 on each DS_ERR1 entry and saturate at 8'hFF with no wrap.
REQ-028 Slave wait states (HREADYOUT_i[k] = 0) shall be passed through indefinitely.
- sel_q holds throughout; no timeout.
REQ-029 A slave-originated ERROR is forwarded unmodified and shall not change err_cnt_o.
REQ-030 Block is write-direction agnostic: HRESP/HREADY apply to reads and writes; HRDATA_o is meaningful only for reads.

Reset
REQ-031 While HRST = 1:
- sel_q = DEFAULT, FSM = DS_OK, err_cnt_o = 0.
- HREADY_o = 1, HRESP_o = 0, HRDATA_o = 0.
REQ-032 Reset asserted mid-transfer or mid-ERROR shall abort immediately to the REQ-031 values without completing the ERROR sequence.
REQ-033 First address phase is accepted on the first rising HCLK after HRST deasserts.

Verification
REQ-034 HSEL_i = 16'h0004, NONSEQ; next cycle HRDATA_i[2] = 32'hDEADBEEF, HREADYOUT_i[2] = 1 -> HRDATA_o = 32'hDEADBEEF, HREADY_o = 1, HRESP_o = 0.
REQ-035 Slave 5 selected, HREADYOUT_i[5] low 3 cycles; HSEL_i changes to 16'h0001 during the wait -> HREADY_o low 3 cycles, then data from slave 5, then slave 0.
REQ-036 HSEL_i = 0 with NONSEQ -> HREADY_o/HRESP_o = 0/1 then 1/1, HRDATA_o = 0, err_cnt_o 0 -> 1.
REQ-037 HSEL_i = 16'h0003 with SEQ -> default-slave ERROR sequence; HSEL_i = 0 with IDLE -> one-cycle OKAY, err_cnt_o unchanged.
REQ-038 Drive 300 consecutive unmapped NONSEQ transfers -> err_cnt_o = 8'hFF with no wrap.
REQ-039 Assert HRST during DS_ERR1 -> outputs immediately HREADY_o = 1, HRESP_o = 0, err_cnt_o = 0.
